// File: rtl/axi_sram_slave.sv
// Single-beat AXI slave in front of a synchronous single-port SRAM (1-cycle read latency).
// Optional macro AXI_SRAM_SLAVE_DECERR_EN: out-of-range addresses get DECERR instead of aliasing.
module axi_sram_slave #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int WORD_OFS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [DEPTH_LOG2-1:0] sram_addr,
    output logic [DATA_W/8-1:0]   sram_be,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata
);

    localparam int HI_LSB = WORD_OFS + DEPTH_LOG2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_RESP
    } state_t;

    state_t state, state_nx;
    logic   prio_wr, prio_wr_nx;
    logic   rd_elig, wr_elig;
    logic   grant_rd, grant_wr;
    logic   rd_err, wr_err;
    logic   rd_err_q;

    // The byte offset never selects anything: the SRAM is only accessed in whole words
    logic unused_ofs;
    assign unused_ofs = ^{s_araddr[WORD_OFS-1:0], s_awaddr[WORD_OFS-1:0]};

`ifdef AXI_SRAM_SLAVE_DECERR_EN
    assign rd_err = |s_araddr[ADDR_W-1:HI_LSB];
    assign wr_err = |s_awaddr[ADDR_W-1:HI_LSB];
`else
    logic unused_hi;
    assign unused_hi = ^{s_araddr[ADDR_W-1:HI_LSB], s_awaddr[ADDR_W-1:HI_LSB]};
    assign rd_err    = 1'b0;
    assign wr_err    = 1'b0;
`endif

    assign rd_elig  = s_arvalid;
    assign wr_elig  = s_awvalid & s_wvalid;
    assign grant_rd = (state == IDLE) & rd_elig & (~wr_elig | ~prio_wr);
    assign grant_wr = (state == IDLE) & wr_elig & (~rd_elig | prio_wr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prio_wr <= 1'b0;
        end else begin
            state   <= state_nx;
            prio_wr <= prio_wr_nx;
        end
    end

    // Priority flips to the side that was not just served; AW and W are always taken together
    always_comb begin
        state_nx   = state;
        prio_wr_nx = prio_wr;
        s_arready  = 1'b0;
        s_awready  = 1'b0;
        s_wready   = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = s_araddr[WORD_OFS +: DEPTH_LOG2];
        sram_be    = '0;
        sram_wdata = '0;
        case (state)
            IDLE: begin
                if (grant_rd) begin
                    s_arready  = 1'b1;
                    sram_en    = ~rd_err;
                    prio_wr_nx = 1'b1;
                    state_nx   = RD_WAIT;
                end else if (grant_wr) begin
                    s_awready  = 1'b1;
                    s_wready   = 1'b1;
                    sram_en    = ~wr_err;
                    sram_we    = ~wr_err;
                    sram_addr  = s_awaddr[WORD_OFS +: DEPTH_LOG2];
                    sram_be    = s_wstrb;
                    sram_wdata = s_wdata;
                    prio_wr_nx = 1'b0;
                    state_nx   = WR_RESP;
                end
            end
            RD_WAIT: state_nx = RD_RESP;
            RD_RESP: if (s_rready) state_nx = IDLE;
            WR_RESP: if (s_bready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Response channels are registered so rvalid/bvalid and their payloads stay stable under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
            rd_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        rd_err_q <= rd_err;
                    end else if (grant_wr) begin
                        s_bvalid <= 1'b1;
                        s_bresp  <= wr_err ? RESP_DECERR : RESP_OKAY;
                    end
                end
                RD_WAIT: begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= rd_err_q ? '0 : sram_rdata;
                    s_rresp  <= rd_err_q ? RESP_DECERR : RESP_OKAY;
                end
                RD_RESP: if (s_rready) s_rvalid <= 1'b0;
                WR_RESP: if (s_bready) s_bvalid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural 1-cycle-latency SRAM model.
// Expectations for the out-of-range read follow AXI_SRAM_SLAVE_DECERR_EN when it is defined.
module tb_axi_sram_slave;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int DEPTH_LOG2 = 10;
    localparam int WORD_OFS   = 2;

    logic                  clk;
    logic                  rst;
    logic [ADDR_W-1:0]     s_araddr;
    logic                  s_arvalid;
    logic                  s_arready;
    logic [DATA_W-1:0]     s_rdata;
    logic [1:0]            s_rresp;
    logic                  s_rvalid;
    logic                  s_rready;
    logic [ADDR_W-1:0]     s_awaddr;
    logic                  s_awvalid;
    logic                  s_awready;
    logic [DATA_W-1:0]     s_wdata;
    logic [DATA_W/8-1:0]   s_wstrb;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [1:0]            s_bresp;
    logic                  s_bvalid;
    logic                  s_bready;
    logic                  sram_en;
    logic                  sram_we;
    logic [DEPTH_LOG2-1:0] sram_addr;
    logic [DATA_W/8-1:0]   sram_be;
    logic [DATA_W-1:0]     sram_wdata;
    logic [DATA_W-1:0]     sram_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int en_cnt    = 0;
    int wr_cnt    = 0;

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    axi_sram_slave #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .WORD_OFS(WORD_OFS)
    ) dut (
        .clk(clk), .rst(rst),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_be(sram_be),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < (1 << DEPTH_LOG2); i++) mem[i] = '0;
    end

    // SRAM model: byte-enabled write, read data presented the cycle after the request
    always @(posedge clk) begin
        if (sram_en) begin
            en_cnt <= en_cnt + 1;
            if (sram_we) begin
                wr_cnt <= wr_cnt + 1;
                for (int b = 0; b < DATA_W/8; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int n;
        s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        #1;
        n = 0;
        while (s_awready !== 1'b1 && n < 10) begin tick(); n++; end
        if (n == 10) begin
            total_cnt++;
            $display("[TB] FAIL write_aw_timeout addr=%h", a);
        end
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n = 0;
        while (s_bvalid !== 1'b1 && n < 10) begin tick(); n++; end
        if (n == 10) begin
            total_cnt++;
            $display("[TB] FAIL write_b_timeout addr=%h", a);
        end
        resp = s_bresp;
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
        #1;
        n = 0;
        while (s_arready !== 1'b1 && n < 10) begin tick(); n++; end
        if (n == 10) begin
            total_cnt++;
            $display("[TB] FAIL read_ar_timeout addr=%h", a);
        end
        tick();
        s_arvalid = 1'b0;
        n = 0;
        while (s_rvalid !== 1'b1 && n < 10) begin tick(); n++; end
        if (n == 10) begin
            total_cnt++;
            $display("[TB] FAIL read_r_timeout addr=%h", a);
        end
        d = s_rdata;
        resp = s_rresp;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({s_rvalid, s_bvalid, s_rresp, s_bresp} !== 6'b0)
            $display("[TB] FAIL reset_valids got=%b want=000000", {s_rvalid, s_bvalid, s_rresp, s_bresp});
        else pass_cnt++;
        total_cnt++;
        if (s_rdata !== 32'h0) $display("[TB] FAIL reset_rdata got=%h want=0", s_rdata);
        else pass_cnt++;
        total_cnt++;
        if ({s_arready, s_awready, s_wready, sram_en} !== 4'b0)
            $display("[TB] FAIL reset_ready got=%b want=0000", {s_arready, s_awready, s_wready, sram_en});
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        s_awaddr = 32'h10; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        #1;
        total_cnt++;
        if ({s_awready, s_wready, sram_en, sram_we} !== 4'b1111 || sram_addr !== 10'd4 ||
            sram_be !== 4'hF || sram_wdata !== 32'hDEADBEEF)
            $display("[TB] FAIL wr_issue got rdy/en/we=%b addr=%0d be=%h wd=%h want 1111 4 f deadbeef",
                     {s_awready, s_wready, sram_en, sram_we}, sram_addr, sram_be, sram_wdata);
        else pass_cnt++;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        total_cnt++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00)
            $display("[TB] FAIL wr_bvalid got=%b resp=%b want=1 00", s_bvalid, s_bresp);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (s_bvalid !== 1'b0) $display("[TB] FAIL wr_bclear got=%b want=0", s_bvalid);
        else pass_cnt++;
        s_araddr = 32'h10; s_arvalid = 1'b1; s_rready = 1'b1;
        #1;
        total_cnt++;
        if ({s_arready, sram_en, sram_we} !== 3'b110 || sram_addr !== 10'd4)
            $display("[TB] FAIL rd_issue got=%b addr=%0d want=110 4", {s_arready, sram_en, sram_we}, sram_addr);
        else pass_cnt++;
        tick();
        s_arvalid = 1'b0;
        total_cnt++;
        if (s_rvalid !== 1'b0) $display("[TB] FAIL rd_latency1 got rvalid=%b want=0", s_rvalid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'hDEADBEEF || s_rresp !== 2'b00)
            $display("[TB] FAIL rd_data got v=%b d=%h r=%b want 1 deadbeef 00", s_rvalid, s_rdata, s_rresp);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (s_rvalid !== 1'b0) $display("[TB] FAIL rd_clear got=%b want=0", s_rvalid);
        else pass_cnt++;
    endtask

    task automatic test_strobe();
        logic [1:0]  resp;
        logic [31:0] d;
        do_write(32'h20, 32'h11223344, 4'hF, resp);
        do_write(32'h20, 32'h0000AA00, 4'h2, resp);
        do_read(32'h20, d, resp);
        total_cnt++;
        if (d !== 32'h1122AA44) $display("[TB] FAIL strobe_merge got=%h want=1122aa44", d);
        else pass_cnt++;
    endtask

    task automatic test_arbitration();
        logic [7:0] g [0:3];
        logic [7:0] want [0:3];
        int gi;
        int n;
        want[0] = "R"; want[1] = "W"; want[2] = "R"; want[3] = "W";
        for (int i = 0; i < 4; i++) g[i] = "-";
        s_araddr = 32'h40; s_awaddr = 32'h44; s_wdata = 32'h5A5A5A5A; s_wstrb = 4'hF;
        s_arvalid = 1'b1; s_awvalid = 1'b1; s_wvalid = 1'b1; s_rready = 1'b1; s_bready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        gi = 0; n = 0;
        while (gi < 4 && n < 30) begin
            if (s_arready === 1'b1) begin g[gi] = "R"; gi++; end
            else if (s_awready === 1'b1 && s_wready === 1'b1) begin g[gi] = "W"; gi++; end
            tick();
            n++;
        end
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (g[i] !== want[i]) $display("[TB] FAIL arb_grant%0d got=%c want=%c", i, g[i], want[i]);
            else pass_cnt++;
        end
        tick(); tick(); tick();
    endtask

    task automatic test_backpressure();
        logic [1:0]  resp;
        logic [31:0] d;
        s_araddr = 32'h20; s_arvalid = 1'b1; s_rready = 1'b0;
        #1;
        tick();
        s_araddr = 32'h10;
        tick(); tick();
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if (s_rvalid !== 1'b1 || s_rdata !== 32'h1122AA44 || s_arready !== 1'b0)
                $display("[TB] FAIL bp_hold%0d got v=%b d=%h ar=%b want 1 1122aa44 0",
                         c, s_rvalid, s_rdata, s_arready);
            else pass_cnt++;
            tick();
        end
        s_rready = 1'b1;
        #1;
        total_cnt++;
        if (s_arready !== 1'b0) $display("[TB] FAIL bp_hs_cycle got ar=%b want=0", s_arready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (s_arready !== 1'b1 || s_rvalid !== 1'b0)
            $display("[TB] FAIL bp_next_ar got ar=%b v=%b want 1 0", s_arready, s_rvalid);
        else pass_cnt++;
        tick();
        s_arvalid = 1'b0;
        tick(); 
        total_cnt++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'hDEADBEEF)
            $display("[TB] FAIL bp_second_read got v=%b d=%h want 1 deadbeef", s_rvalid, s_rdata);
        else pass_cnt++;
        tick();
        do_read(32'h10, d, resp);
    endtask

    task automatic test_aw_without_w();
        int wr0;
        logic [1:0]  resp;
        logic [31:0] d;
        wr0 = wr_cnt;
        s_awaddr = 32'h30; s_wdata = 32'hCAFE0001; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b0; s_bready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++;
            if ({s_awready, s_wready, sram_en} !== 3'b000)
                $display("[TB] FAIL aw_only%0d got=%b want=000", c, {s_awready, s_wready, sram_en});
            else pass_cnt++;
            tick();
        end
        s_wvalid = 1'b1;
        #1;
        total_cnt++;
        if ({s_awready, s_wready} !== 2'b11)
            $display("[TB] FAIL aw_w_both got=%b want=11", {s_awready, s_wready});
        else pass_cnt++;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        tick(); tick(); tick();
        total_cnt++;
        if (wr_cnt - wr0 !== 1) $display("[TB] FAIL aw_single_write got=%0d want=1", wr_cnt - wr0);
        else pass_cnt++;
        do_read(32'h30, d, resp);
        total_cnt++;
        if (d !== 32'hCAFE0001) $display("[TB] FAIL aw_readback got=%h want=cafe0001", d);
        else pass_cnt++;
    endtask

    task automatic test_alias();
        logic [1:0]  resp;
        logic [31:0] d;
        int en0;
        do_write(32'h0, 32'hCAFEF00D, 4'hF, resp);
        en0 = en_cnt;
        s_araddr = 32'h0001_0000; s_arvalid = 1'b1; s_rready = 1'b1;
        #1;
        total_cnt++;
`ifdef AXI_SRAM_SLAVE_DECERR_EN
        if (s_arready !== 1'b1 || sram_en !== 1'b0)
            $display("[TB] FAIL oor_issue got ar=%b en=%b want 1 0", s_arready, sram_en);
        else pass_cnt++;
`else
        if (s_arready !== 1'b1 || sram_en !== 1'b1 || sram_addr !== 10'd0)
            $display("[TB] FAIL alias_issue got ar=%b en=%b addr=%0d want 1 1 0", s_arready, sram_en, sram_addr);
        else pass_cnt++;
`endif
        tick();
        s_arvalid = 1'b0;
        tick();
        total_cnt++;
`ifdef AXI_SRAM_SLAVE_DECERR_EN
        if (s_rvalid !== 1'b1 || s_rdata !== 32'h0 || s_rresp !== 2'b11)
            $display("[TB] FAIL oor_read got v=%b d=%h r=%b want 1 0 11", s_rvalid, s_rdata, s_rresp);
        else pass_cnt++;
`else
        if (s_rvalid !== 1'b1 || s_rdata !== 32'hCAFEF00D || s_rresp !== 2'b00)
            $display("[TB] FAIL alias_read got v=%b d=%h r=%b want 1 cafef00d 00", s_rvalid, s_rdata, s_rresp);
        else pass_cnt++;
`endif
        tick();
        do_write(32'h0001_0000, 32'h12345678, 4'hF, resp);
        total_cnt++;
`ifdef AXI_SRAM_SLAVE_DECERR_EN
        if (resp !== 2'b11 || en_cnt !== en0)
            $display("[TB] FAIL oor_write got resp=%b en_pulses=%0d want 11 0", resp, en_cnt - en0);
        else pass_cnt++;
        do_read(32'h0, d, resp);
        total_cnt++;
        if (d !== 32'hCAFEF00D) $display("[TB] FAIL oor_nowrite got=%h want=cafef00d", d);
        else pass_cnt++;
`else
        if (resp !== 2'b00) $display("[TB] FAIL alias_bresp got=%b want=00", resp);
        else pass_cnt++;
        do_read(32'h0, d, resp);
        total_cnt++;
        if (d !== 32'h12345678) $display("[TB] FAIL alias_write got=%h want=12345678", d);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        s_araddr = 32'h10; s_arvalid = 1'b1; s_rready = 1'b0;
        #1;
        tick();
        s_arvalid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if (s_rvalid !== 1'b0 || s_rdata !== 32'h0)
            $display("[TB] FAIL rst_mid got v=%b d=%h want 0 0", s_rvalid, s_rdata);
        else pass_cnt++;
        s_rready = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_strobe();
        test_arbitration();
        idle_inputs();
        test_backpressure();
        idle_inputs();
        test_aw_without_w();
        idle_inputs();
        test_alias();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- Single-beat AXI slave that terminates transactions issued by the core's AXI master port.
- Serves reads and writes from a synchronous single-port SRAM with 1-cycle read latency.
- Sits directly downstream of the load/store AXI master. Used as on-chip scratchpad / test memory behind the data port.
- Supports only the burst-free traffic the master generates: len=0, one outstanding transaction at a time.

Parameters:
DATA_W, 32, AXI data and SRAM word width (bits); strobe width is DATA_W/8
ADDR_W, 32, AXI address width
DEPTH_LOG2, 10, log2 of SRAM depth in words
WORD_OFS, 2, log2(DATA_W/8); byte-offset bits dropped from the address

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_araddr  in  ADDR_W  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  DATA_W  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_awaddr  in  ADDR_W  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  DATA_W  write data
s_wstrb  in  DATA_W/8  write byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
sram_en  out  1  SRAM access enable
sram_we  out  1  SRAM write enable
sram_addr  out  DEPTH_LOG2  SRAM word index
sram_be  out  DATA_W/8  SRAM byte enables
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_en & ~sram_we

Behaviour:
- Reset and clock: clk clock; rst synchronous, active-high.
- Reset values: state=IDLE, s_rvalid=0, s_bvalid=0, s_rresp=0, s_bresp=0, s_rdata=0, prio=read.
- Ready signals are combinational from state and valids. sram_* outputs are combinational.
- arlen, awlen, size and burst are not ported; wstrb alone determines written bytes.

States:
- IDLE: only state in which arready/awready/wready can assert.
  - Write eligible only when s_awvalid & s_wvalid are both high. AW and W are accepted in the same cycle; awready=wready, never one without the other.
  - Read eligible when s_arvalid.
  - Both eligible: grant to prio. prio toggles to the other side after each grant; otherwise prio is unchanged.
  - Read grant: s_arready=1, sram_en=1, sram_we=0, sram_addr=s_araddr[WORD_OFS +: DEPTH_LOG2]; go to RD_WAIT.
  - Write grant: s_awready=s_wready=1, sram_en=sram_we=1, sram_be=s_wstrb, sram_wdata=s_wdata, sram_addr from s_awaddr; register s_bvalid=1, s_bresp=OKAY; go to WR_RESP.
- RD_WAIT: s_rdata<=sram_rdata, s_rvalid<=1, s_rresp<=OKAY; go to RD_RESP.
  - AR handshake at cycle N gives rvalid first high at N+2.
- RD_RESP: hold s_rvalid and s_rdata stable until s_rready. On handshake, clear s_rvalid and go to IDLE.
  - New requests are accepted no earlier than the cycle after the R handshake.
- WR_RESP: s_bvalid high from cycle after the AW/W handshake. Hold until s_bready; then clear and go to IDLE.

Boundary and corner cases:
- s_rready / s_bready already high on the first valid cycle: handshake completes in that cycle.
- Minimum throughput: read 1 per 3 cycles, write 1 per 2 cycles.
- sram_en=0 in every state except IDLE-with-grant.
- Valid deasserted by the master before ready (protocol violation): no requirement.
- AW valid without W (or W without AW): nothing is accepted; any pending AR may be granted meanwhile.
- Reset mid-operation: pending response is dropped and state returns to IDLE. An SRAM write already issued remains committed.
- Address bits above WORD_OFS+DEPTH_LOG2: ignored (alias) unless the feature below is enabled.

Optional Feature:
- Macro: AXI_SRAM_SLAVE_DECERR_EN.
- Defined:
  - Address with any nonzero bit in [ADDR_W-1 : WORD_OFS+DEPTH_LOG2] is handshaken normally, but sram_en stays 0.
  - Read: s_rdata=0, s_rresp=2'b11 (DECERR), same 2-cycle latency.
  - Write: no SRAM write, s_bresp=2'b11.
- Undefined: upper bits ignored, responses always 2'b00.

Test Plan:
1. Write 0xDEADBEEF to addr 0x10 with wstrb=0xF, bready=1 -> sram_we pulse with sram_addr=4; bvalid one cycle later, bresp=0. Then read 0x10 with rready=1 -> rvalid at AR+2, rdata=0xDEADBEEF.
2. Write wstrb=0x2, wdata=0x0000AA00 to a word holding 0x11223344 -> readback gives 0x1122AA44.
3. arvalid, awvalid and wvalid all high continuously from reset -> grants alternate R, W, R, W, with read first.
4. Hold rready=0 for 5 cycles -> rvalid and rdata stable; arready=0 throughout; next AR accepted the cycle after the R handshake.
5. awvalid=1 with wvalid=0 for 3 cycles, then wvalid=1 -> awready=0 until both valid; single write issued.
6. With AXI_SRAM_SLAVE_DECERR_EN, read 0x0001_0000 (DEPTH_LOG2=10) -> rresp=3, rdata=0, sram_en never high. Without the macro: rresp=0 and sram_addr=0 (alias).
